// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port word memory between two requesters,
// with read-modify-write for byte-enable stores. Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [3:0]            p0_be,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [31:0]           p0_wdata,
    output logic                  p0_rsp_valid,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [3:0]            p1_be,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [31:0]           p1_wdata,
    output logic                  p1_rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                    last_grant_r;
`endif
    logic                    grant0_s;
    logic                    grant1_s;
    logic                    accept_s;
    logic                    acc_port_s;
    logic                    sel_we_s;
    logic [3:0]              sel_be_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [31:0]             sel_wdata_s;
    logic                    sel_partial_s;
    logic [ADDR_WIDTH-1:0]   merge_addr_r;
    logic [31:0]             merge_data_r;
    logic                    merge_port_r;

    function automatic logic [31:0] merge_word(input logic [3:0]  be,
                                               input logic [31:0] wdata,
                                               input logic [31:0] rdata);
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
        end
        return res;
    endfunction

    // Grant selection: only in IDLE and never while reset is held
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == IDLE && !rst) begin
            if (p0_valid && p1_valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                grant0_s = 1'b1;
`else
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
`endif
            end else begin
                grant0_s = p0_valid;
                grant1_s = p1_valid & ~p0_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign p0_ready      = grant0_s;
    assign p1_ready      = grant1_s;
    assign accept_s      = grant0_s | grant1_s;
    assign acc_port_s    = grant1_s;
    assign sel_we_s      = acc_port_s ? p1_we    : p0_we;
    assign sel_be_s      = acc_port_s ? p1_be    : p0_be;
    assign sel_addr_s    = acc_port_s ? p1_addr  : p0_addr;
    assign sel_wdata_s   = acc_port_s ? p1_wdata : p0_wdata;
    assign sel_partial_s = sel_we_s && (sel_be_s != 4'h0) && (sel_be_s != 4'hF);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: only a partial store detours through MERGE
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s && sel_partial_s) begin
                    state_next_s = MERGE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MERGE:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Memory strobe generation; all fields zero when no access is made
    always_comb begin
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_addr       = '0;
        mem_write_data = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (accept_s && !sel_we_s) begin
                    mem_read_en = 1'b1;
                    mem_addr    = sel_addr_s;
                end else if (accept_s && sel_be_s == 4'hF) begin
                    mem_write_en   = 1'b1;
                    mem_addr       = sel_addr_s;
                    mem_write_data = sel_wdata_s;
                end else if (accept_s && sel_partial_s) begin
                    mem_read_en = 1'b1;
                    mem_addr    = sel_addr_s;
                end else begin
                    mem_read_en = 1'b0;
                end
            end
            MERGE: begin
                if (!rst) begin
                    mem_write_en   = 1'b1;
                    mem_addr       = merge_addr_r;
                    mem_write_data = merge_data_r;
                end else begin
                    mem_write_en = 1'b0;
                end
            end
            default: mem_write_en = 1'b0;
        endcase
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Round-robin history, updated on every accept
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= acc_port_s;
        end
    end
`endif

    // Response pulses, load data and the pending merge context
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            rsp_rdata    <= 32'h0000_0000;
            merge_addr_r <= '0;
            merge_data_r <= 32'h0000_0000;
            merge_port_r <= 1'b0;
        end else begin
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            if (accept_s && sel_partial_s) begin
                merge_addr_r <= sel_addr_s;
                merge_data_r <= merge_word(sel_be_s, sel_wdata_s, mem_read_data);
                merge_port_r <= acc_port_s;
            end else if (accept_s) begin
                p0_rsp_valid <= ~acc_port_s;
                p1_rsp_valid <= acc_port_s;
                rsp_rdata    <= sel_we_s ? 32'h0000_0000 : mem_read_data;
            end else if (state_r == MERGE) begin
                p0_rsp_valid <= ~merge_port_r;
                p1_rsp_valid <= merge_port_r;
                rsp_rdata    <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses,
// a negedge monitor pops and checks port, data and arrival cycle.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic        p0_ready, p1_ready;
    logic        p0_we = 1'b0, p1_we = 1'b0;
    logic [3:0]  p0_be = 4'h0, p1_be = 4'h0;
    logic [7:0]  p0_addr = 8'h00, p1_addr = 8'h00;
    logic [31:0] p0_wdata = 32'h0, p1_wdata = 32'h0;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_read_en, mem_write_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_write_data, mem_read_data;

    logic [31:0] mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'h00;
    logic [31:0] bd_data = 32'h0;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    dmem_arbiter #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_be(p0_be),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_be(p1_be),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
        .rsp_rdata(rsp_rdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read, write on the clock edge, backdoor preload
    assign mem_read_data = mem[mem_addr];
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_write_en) mem[mem_addr] <= mem_write_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: strobe exclusivity every cycle, responses against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_excl", {63'd0, mem_read_en & mem_write_en}, 64'd0);
            if (p0_rsp_valid || p1_rsp_valid) begin
                if (p0_rsp_valid && p1_rsp_valid) begin
                    check("dual_rsp", 64'd1, 64'd0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {63'd0, p1_rsp_valid}, 64'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_port", {63'd0, p1_rsp_valid}, 64'(e.port));
                    check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.data});
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic drive(input int port, input logic we, input logic [3:0] be,
                         input logic [7:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wdata; p0_valid = 1'b1;
        end else begin
            p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wdata; p1_valid = 1'b1;
        end
    endtask

    // Issue one request, wait (bounded) for accept, check strobes, queue the response
    task automatic req(input int port, input logic we, input logic [3:0] be,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_re,
                       input logic exp_we, input bit push);
        bit got;
        bit partial;
        got = 1'b0;
        partial = we && be != 4'h0 && be != 4'hF;
        drive(port, we, be, addr, wdata);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_ready : p1_ready) got = 1'b1;
        end
        if (!got) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            check("accept_strobes", {62'd0, mem_read_en, mem_write_en}, {62'd0, exp_re, exp_we});
            if (exp_re || exp_we) check("accept_addr", {56'd0, mem_addr}, {56'd0, addr});
            if (exp_we) check("accept_wdata", {32'd0, mem_write_data}, {32'd0, wdata});
            if (push) exp_q.push_back('{port, exp_rdata, cyc + (partial ? 2 : 1)});
        end
        @(posedge clk); #1;
        if (port == 0) p0_valid = 1'b0; else p1_valid = 1'b0;
    endtask

    initial begin
        // Reset: memory preload, ready and strobes held low
        bd_write(8'h10, 32'hDEADBEEF);
        bd_write(8'h30, 32'hAABBCCDD);
        bd_write(8'h40, 32'h55AA55AA);
        drive(0, 1'b0, 4'hF, 8'h10, 32'h0);
        @(negedge clk);
        check("rst_ready", {62'd0, p0_ready, p1_ready}, 64'd0);
        check("rst_strobes", {62'd0, mem_read_en, mem_write_en}, 64'd0);
        check("rst_rsp", {30'd0, p0_rsp_valid, p1_rsp_valid, rsp_rdata}, 64'd0);
        p0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: load
        req(0, 1'b0, 4'hF, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        // 2: full store then read back
        req(0, 1'b1, 4'hF, 8'h20, 32'h12345678, 32'h0, 1'b0, 1'b1, 1'b1);
        req(0, 1'b0, 4'hF, 8'h20, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b1);

        // 3: partial store via read-modify-write
        req(1, 1'b1, 4'b0101, 8'h30, 32'h11223344, 32'h0, 1'b1, 1'b0, 1'b1);
        drive(0, 1'b0, 4'hF, 8'h10, 32'h0);
        @(negedge clk);
        check("merge_we", {62'd0, mem_read_en, mem_write_en}, 64'd1);
        check("merge_addr", {56'd0, mem_addr}, 64'h30);
        check("merge_data", {32'd0, mem_write_data}, 64'hAA22CC44);
        check("merge_ready", {62'd0, p0_ready, p1_ready}, 64'd0);
        req(0, 1'b0, 4'hF, 8'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("mem30_merged", {32'd0, mem[8'h30]}, 64'hAA22CC44);

        // 6: empty store
        req(0, 1'b1, 4'h0, 8'h40, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("mem40_kept", {32'd0, mem[8'h40]}, 64'h55AA55AA);

        // 4: both ports continuously valid right after reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 4'hF, 8'h10, 32'h0);
        drive(1, 1'b0, 4'hF, 8'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            int exp_g;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            @(negedge clk);
            check("rr_grant", {62'd0, p1_ready, p0_ready}, (exp_g == 1) ? 64'd2 : 64'd1);
            exp_q.push_back('{exp_g, (exp_g == 1) ? 32'h12345678 : 32'hDEADBEEF, cyc + 1});
            @(posedge clk); #1;
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 5: reset during MERGE drops the write and the ack
        bd_write(8'h30, 32'hAABBCCDD);
        req(1, 1'b1, 4'b0101, 8'h30, 32'h11223344, 32'h0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_merge_we", {63'd0, mem_write_en}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mem30_kept", {32'd0, mem[8'h30]}, 64'hAABBCCDD);
        req(1, 1'b0, 4'hF, 8'h30, 32'h0, 32'hAABBCCDD, 1'b1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
